// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: counts frames, then launches a random-sized wave
// of fruits into free object slots through a valid/ready request port.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   new_frame_in            one-cycle pulse per video frame
//   game_active_in          round in play
//   random_in               free-running LFSR word
//   slot_busy_in            per-slot in-flight flags
//   random_sample_out       registered random word for the position lookup
//   x_start_in .. x_dir_neg_in  lookup results for random_sample_out
//   spawn_valid_out/ready_in    launch handshake
//   spawn_slot_out, spawn_x_out, spawn_xvel_out, spawn_yvel_out,
//   spawn_xneg_out          launch parameters, held while valid
//   wave_done_out           one-cycle pulse at end of each wave
module fruit_spawn_scheduler #(
   parameter int NUM_SLOTS      = 4,
   parameter int SPAWN_INTERVAL = 60,
   parameter int MAX_BATCH      = 3,
   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 new_frame_in,
   input  logic                 game_active_in,
   input  logic [15:0]          random_in,
   input  logic [NUM_SLOTS-1:0] slot_busy_in,
   output logic [15:0]          random_sample_out,
   input  logic [10:0]          x_start_in,
   input  logic [2:0]           x_vel_in,
   input  logic [4:0]           y_vel_in,
   input  logic                 x_dir_neg_in,
   output logic                 spawn_valid_out,
   input  logic                 spawn_ready_in,
   output logic [SW-1:0]        spawn_slot_out,
   output logic [10:0]          spawn_x_out,
   output logic [2:0]           spawn_xvel_out,
   output logic [4:0]           spawn_yvel_out,
   output logic                 spawn_xneg_out,
   output logic                 wave_done_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_CAPTURE,
      S_ISSUE,
      S_DONE
   } state_t;

   state_t               state;
   logic [7:0]           frame_cnt;
   logic [2:0]           batch_remaining;
   logic [NUM_SLOTS-1:0] used_mask;

   logic [2:0]           batch_req;
   logic [2:0]           batch_init;
   logic [NUM_SLOTS-1:0] free_slots;
   logic                 any_free;
   logic [SW-1:0]        free_idx;
   logic                 frame_hit;

   assign batch_req  = {1'b0, random_in[13:12]} + 3'd1;
   assign batch_init = (batch_req > MAX_BATCH[2:0]) ? MAX_BATCH[2:0]
                                                    : batch_req;
   assign frame_hit  = (frame_cnt + 8'd1) == SPAWN_INTERVAL[7:0];

   // Slots already picked this wave are masked out, since the slot logic
   // may not have raised its busy flag yet.
   always_comb begin
      free_slots = ~slot_busy_in & ~used_mask;
      any_free   = |free_slots;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_slots[i]) free_idx = SW'(i);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state             <= S_IDLE;
         frame_cnt         <= '0;
         batch_remaining   <= '0;
         used_mask         <= '0;
         random_sample_out <= '0;
         spawn_valid_out   <= 1'b0;
         spawn_slot_out    <= '0;
         spawn_x_out       <= '0;
         spawn_xvel_out    <= '0;
         spawn_yvel_out    <= '0;
         spawn_xneg_out    <= 1'b0;
         wave_done_out     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               frame_cnt <= '0;
               if (game_active_in) state <= S_WAIT;
            end
            S_WAIT: begin
               if (!game_active_in) begin
                  frame_cnt <= '0;
                  state     <= S_IDLE;
               end else if (new_frame_in) begin
                  if (frame_hit) begin
                     frame_cnt       <= '0;
                     batch_remaining <= batch_init;
                     used_mask       <= '0;
                     state           <= S_SAMPLE;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            S_SAMPLE: begin
               if (!game_active_in) begin
                  state <= S_IDLE;
               end else begin
                  random_sample_out <= random_in;
                  state             <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (!game_active_in) begin
                  state <= S_IDLE;
               end else if (any_free) begin
                  spawn_slot_out  <= free_idx;
                  spawn_x_out     <= x_start_in;
                  spawn_xvel_out  <= x_vel_in;
                  spawn_yvel_out  <= y_vel_in;
                  spawn_xneg_out  <= x_dir_neg_in;
                  used_mask       <= used_mask
                                   | (NUM_SLOTS'(1) << free_idx);
                  spawn_valid_out <= 1'b1;
                  state           <= S_ISSUE;
               end else begin
                  wave_done_out <= 1'b1;
                  state         <= S_DONE;
               end
            end
            S_ISSUE: begin
               // The request is held through a game stop; it only
               // retires on a completed transfer.
               if (spawn_ready_in) begin
                  spawn_valid_out <= 1'b0;
                  batch_remaining <= batch_remaining - 3'd1;
                  if (!game_active_in) begin
                     state <= S_IDLE;
                  end else if (batch_remaining == 3'd1) begin
                     wave_done_out <= 1'b1;
                     state         <= S_DONE;
                  end else begin
                     state <= S_SAMPLE;
                  end
               end
            end
            S_DONE: begin
               wave_done_out <= 1'b0;
               state <= game_active_in ? S_WAIT : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed scoreboard bench for fruit_spawn_scheduler: expected launches
// are queued per wave and retired as the DUT hands them off.
module tb_fruit_spawn_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_frame;
   logic        active;
   logic [15:0] rnd;
   logic [3:0]  busy;
   logic [15:0] rsample;
   logic [10:0] x_start;
   logic [2:0]  x_vel;
   logic [4:0]  y_vel;
   logic        x_neg;
   logic        valid;
   logic        ready;
   logic [1:0]  slot;
   logic [10:0] sx;
   logic [2:0]  sxv;
   logic [4:0]  syv;
   logic        sxn;
   logic        done;

   int vectors     = 0;
   int miscompares = 0;
   int launches    = 0;
   int done_cnt    = 0;
   int stall_cnt   = 0;

   logic [21:0] q[$];

   always #5 clk = ~clk;

   fruit_spawn_scheduler dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .new_frame_in      (new_frame),
      .game_active_in    (active),
      .random_in         (rnd),
      .slot_busy_in      (busy),
      .random_sample_out (rsample),
      .x_start_in        (x_start),
      .x_vel_in          (x_vel),
      .y_vel_in          (y_vel),
      .x_dir_neg_in      (x_neg),
      .spawn_valid_out   (valid),
      .spawn_ready_in    (ready),
      .spawn_slot_out    (slot),
      .spawn_x_out       (sx),
      .spawn_xvel_out    (sxv),
      .spawn_yvel_out    (syv),
      .spawn_xneg_out    (sxn),
      .wave_done_out     (done)
   );

   // Position lookup model: {xneg, yvel, xvel, x}
   function automatic logic [19:0] lut(input logic [15:0] r);
      return {r[3], r[15:11], r[2:0], r[10:0] ^ 11'h2AA};
   endfunction

   logic [19:0] lut_now;
   assign lut_now = lut(rsample);
   assign x_start = lut_now[10:0];
   assign x_vel   = lut_now[13:11];
   assign y_vel   = lut_now[18:14];
   assign x_neg   = lut_now[19];

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [15:0] r);
      q.push_back({s, lut(r)});
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (valid) begin
            if (q.size() == 0) begin
               check("unexpected_launch", {31'd0, valid}, 32'd0);
            end else begin
               check("launch_slot", {30'd0, slot}, {30'd0, q[0][21:20]});
               check("launch_params", {12'd0, sxn, syv, sxv, sx},
                     {12'd0, q[0][19:0]});
               if (ready) begin
                  void'(q.pop_front());
                  launches++;
               end else begin
                  stall_cnt++;
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         new_frame = 1'b1;
         tick();
         new_frame = 1'b0;
         tick();
      end
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 60 && done_cnt < target; i++) tick();
      check("wave_done_count", done_cnt, target);
   endtask

   task automatic wait_valid;
      for (int i = 0; i < 20 && !valid; i++) tick();
      check("valid_wait", {31'd0, valid}, 32'd1);
   endtask

   task automatic check_reset_outputs;
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_slot", {30'd0, slot}, 32'd0);
      check("rst_x", {21'd0, sx}, 32'd0);
      check("rst_xvel", {29'd0, sxv}, 32'd0);
      check("rst_yvel", {27'd0, syv}, 32'd0);
      check("rst_xneg", {31'd0, sxn}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sample", {16'd0, rsample}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      new_frame = 1'b0;
      active    = 1'b0;
      rnd       = 16'h0;
      busy      = 4'h0;
      ready     = 1'b1;
      tick();
      tick();
      check_reset_outputs();
      rst = 1'b0;
      tick();

      // Three-fruit wave into slots 0,1,2
      rnd    = 16'h2A5C;
      active = 1'b1;
      tick();
      push(2'd0, rnd);
      push(2'd1, rnd);
      push(2'd2, rnd);
      frames(59);
      check("no_early_wave1", launches, 0);
      frames(1);
      wait_done(1);
      check("wave1_launches", launches, 3);
      check("wave1_q_empty", q.size(), 0);
      check("wave1_sample", {16'd0, rsample}, {16'd0, rnd});

      // All slots busy: wave ends with no launch
      busy = 4'hF;
      rnd  = 16'h1234;
      frames(60);
      wait_done(2);
      check("full_no_launch", launches, 3);

      // Counter restarted from 0 after the empty wave
      busy = 4'h0;
      rnd  = 16'h0777;
      push(2'd0, rnd);
      frames(59);
      check("no_early_wave3", launches, 3);
      frames(1);
      wait_done(3);
      check("wave3_launches", launches, 4);

      // Batch clamp to MAX_BATCH with slot 0 busy
      busy = 4'b0001;
      rnd  = 16'h3123;
      push(2'd1, rnd);
      push(2'd2, rnd);
      push(2'd3, rnd);
      frames(60);
      wait_done(4);
      check("clamp_launches", launches, 7);
      check("clamp_q_empty", q.size(), 0);

      // Back-pressure: hold for 10 cycles
      ready = 1'b0;
      busy  = 4'b0011;
      rnd   = 16'h0C3A;
      push(2'd2, rnd);
      frames(60);
      wait_valid();
      stall_cnt = 0;
      repeat (10) tick();
      check("stall_cycles", stall_cnt, 10);
      check("stall_no_xfer", launches, 7);
      check("stall_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      tick();
      wait_done(5);
      check("stall_one_xfer", launches, 8);
      check("stall_q_empty", q.size(), 0);

      // Game stop while a request is pending
      ready = 1'b0;
      busy  = 4'h0;
      rnd   = 16'h1555;
      push(2'd0, rnd);
      frames(60);
      wait_valid();
      active = 1'b0;
      repeat (3) tick();
      check("stop_hold_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      repeat (6) tick();
      check("stop_launches", launches, 9);
      check("stop_no_done", done_cnt, 5);
      check("stop_q_empty", q.size(), 0);

      // Game stop mid-count restarts the interval
      active = 1'b1;
      tick();
      frames(30);
      active = 1'b0;
      tick();
      tick();
      active = 1'b1;
      tick();
      rnd = 16'h0ABC;
      push(2'd0, rnd);
      frames(59);
      check("restart_no_early", launches, 9);
      frames(1);
      wait_done(6);
      check("restart_launches", launches, 10);

      // Reset while a request is pending
      ready = 1'b0;
      rnd   = 16'h2001;
      push(2'd0, rnd);
      frames(60);
      wait_valid();
      rst = 1'b1;
      tick();
      check_reset_outputs();
      q.delete();
      rst    = 1'b0;
      ready  = 1'b1;
      active = 1'b0;
      repeat (5) tick();
      check("post_rst_launches", launches, 10);
      check("post_rst_valid", {31'd0, valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
